mat_stream_buf: RTL and testbench



---
 rtl/mat_stream_buf.sv | 139 +++++++++++++
 tb/tb_mat_stream_buf.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_stream_buf.sv
// mat_stream_buf: square-matrix input buffer between the AXI-stream DMA path
// and the matrix compute core. A matrix of n_dim x n_dim elements is captured
// in row-major order from the stream, or all slots are loaded in parallel. The
// full matrix is then held on `out` until the consumer acknowledges it.
//
// Optional feature: define MAT_STREAM_BUF_TLAST_CHECK_EN to enable the sticky
// framing-error flag `err`, which compares s_tlast with the expected last beat.
// Without the macro, s_tlast is ignored and err is tied low.

module mat_stream_buf #(
    parameter int  N_MAX = 4,
    parameter int  WIDTH = 32,
    localparam int LEN   = N_MAX * N_MAX,
    localparam int DW    = $clog2(N_MAX + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DW-1:0]          n_dim,
    input  logic [WIDTH-1:0]       s_tdata,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic                   s_tlast,
    input  logic                   par_load,
    input  logic [LEN*WIDTH-1:0]   par_in,
    output logic [LEN*WIDTH-1:0]   out,
    output logic                   out_valid,
    input  logic                   out_ack,
    output logic                   busy,
    output logic                   err
);

    // count and total only ever reach LEN, so this width never wraps.
    localparam int CW = $clog2(LEN + 1);
    localparam logic [DW-1:0] N_MAX_DW = DW'(N_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        count_q;
    logic [CW-1:0]        total_q;
    logic [CW-1:0]        total_d;
    logic [LEN*WIDTH-1:0] slots_q;

    logic start_ok;
    logic beat;
    logic last_beat;

    // A start is only meaningful for a dimension the buffer can hold.
    assign start_ok  = start && (n_dim != '0) && (n_dim <= N_MAX_DW);
    assign total_d   = CW'(n_dim) * CW'(n_dim);
    assign beat      = s_tvalid && (state_q == FILL);
    assign last_beat = (count_q == total_q - CW'(1));

    // Status outputs come straight from the state register: no input-to-output path.
    assign s_tready  = (state_q == FILL);
    assign busy      = (state_q == FILL);
    assign out_valid = (state_q == FULL);
    assign out       = slots_q;

    // Capture FSM: state, beat counter, matrix length and slot storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the slot array is reset as well, because an aborted capture
            // must not leave partial data visible on `out`.
            state_q <= IDLE;
            count_q <= '0;
            total_q <= '0;
            slots_q <= '0;
        end else begin
            // NOTE: every register here uses <= so all updates see the
            // pre-edge values of count_q/state_q, regardless of statement order.
            unique case (state_q)
                IDLE: begin
                    if (par_load) begin
                        slots_q <= par_in;
                        state_q <= FULL;
                    end else if (start_ok) begin
                        total_q <= total_d;
                        count_q <= '0;
                        slots_q <= '0;
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    if (beat) begin
                        for (int k = 0; k < LEN; k++) begin
                            if (count_q == CW'(k)) begin
                                slots_q[k*WIDTH +: WIDTH] <= s_tdata;
                            end
                        end
                        count_q <= count_q + CW'(1);
                        if (last_beat) begin
                            state_q <= FULL;
                        end
                    end
                end
                FULL: begin
                    // Release wins; a reload is only taken while the matrix is still held.
                    if (out_ack) begin
                        state_q <= IDLE;
                    end else if (par_load) begin
                        slots_q <= par_in;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef MAT_STREAM_BUF_TLAST_CHECK_EN
    logic err_q;

    // Sticky framing error: s_tlast must mark exactly the beat that completes the matrix.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((state_q == IDLE) && !par_load && start_ok) begin
            err_q <= 1'b0;
        end else if (beat && (s_tlast != last_beat)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_tlast;

    assign unused_tlast = s_tlast;
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_mat_stream_buf.sv
// Self-checking bench for mat_stream_buf (N_MAX=4, WIDTH=32). Stimulus data and
// stream gaps are random; the expected matrix, the sticky error and the cycle
// counts are derived from the buffer's documented behaviour in a small model.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_mat_stream_buf;

    localparam int N_MAX = 4;
    localparam int WIDTH = 32;
    localparam int LEN   = N_MAX * N_MAX;
    localparam int DW    = $clog2(N_MAX + 1);

`ifdef MAT_STREAM_BUF_TLAST_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [DW-1:0]        n_dim;
    logic [WIDTH-1:0]     s_tdata;
    logic                 s_tvalid;
    logic                 s_tready;
    logic                 s_tlast;
    logic                 par_load;
    logic [LEN*WIDTH-1:0] par_in;
    logic [LEN*WIDTH-1:0] out;
    logic                 out_valid;
    logic                 out_ack;
    logic                 busy;
    logic                 err;

    // Reference model state: what the buffer should currently present.
    logic [LEN*WIDTH-1:0] exp_out;
    bit                   exp_err;

    int n_vec  = 0;
    int n_miss = 0;

    mat_stream_buf #(.N_MAX(N_MAX), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .n_dim    (n_dim),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tlast  (s_tlast),
        .par_load (par_load),
        .par_in   (par_in),
        .out      (out),
        .out_valid(out_valid),
        .out_ack  (out_ack),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic random_par_in();
        for (int k = 0; k < LEN; k++) par_in[k*WIDTH +: WIDTH] = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0; n_dim = '0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        par_load = 1'b0; par_in = '0; out_ack = 1'b0;
        exp_out = '0; exp_err = 1'b0;
        tick(); tick();
        n_vec++;
        if ({out_valid, busy, s_tready, err} !== 4'b0000) begin
            n_miss++;
            $display("FAIL reset_flags: got v/b/r/e=%b want 0000", {out_valid, busy, s_tready, err});
        end
        n_vec++;
        if (out !== '0) begin
            n_miss++;
            $display("FAIL reset_out: got %h want 0", out);
        end
        rst = 1'b0;
        tick();
    endtask

    // Stream capture. mode 0: tvalid always high, 1: toggling 1,0,1,0, 2: random gaps.
    // bad_last >= 0 additionally raises s_tlast on that beat index.
    task automatic test_capture(input int n, input int mode, input int bad_last);
        int total;
        int acc;
        int cyc;
        logic [WIDTH-1:0] d;
        total = n * n;
        acc = 0;
        cyc = 0;
        start = 1'b1; n_dim = DW'(n);
        tick();
        start = 1'b0;
        exp_out = '0;
        exp_err = 1'b0;
        n_vec++;
        if ({out_valid, busy, s_tready, err} !== 4'b0110) begin
            n_miss++;
            $display("FAIL start_n%0d: got v/b/r/e=%b want 0110", n, {out_valid, busy, s_tready, err});
        end
        while (acc < total) begin
            n_vec++;
            if ({out_valid, s_tready} !== 2'b01) begin
                n_miss++;
                $display("FAIL fill_n%0d_beat%0d: got v/r=%b want 01", n, acc, {out_valid, s_tready});
            end
            case (mode)
                0:       s_tvalid = 1'b1;
                1:       s_tvalid = (cyc % 2 == 0);
                default: s_tvalid = ($urandom_range(0, 3) != 0);
            endcase
            d = $urandom;
            s_tdata = d;
            s_tlast = (acc == total - 1) || (acc == bad_last);
            tick();
            cyc++;
            if (s_tvalid) begin
                exp_out[acc*WIDTH +: WIDTH] = d;
                if (s_tlast != (acc == total - 1)) exp_err = ERR_EN;
                acc++;
            end
            if (cyc > 2000) begin
                n_vec++; n_miss++;
                $display("FAIL fill_n%0d_budget: %0d beats accepted, want %0d", n, acc, total);
                break;
            end
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        if (mode < 2) begin
            n_vec++;
            if (cyc !== ((mode == 0) ? total : 2 * total - 1)) begin
                n_miss++;
                $display("FAIL latency_n%0d_mode%0d: got %0d cycles want %0d", n, mode, cyc,
                         (mode == 0) ? total : 2 * total - 1);
            end
        end
        n_vec++;
        if ({out_valid, busy, s_tready} !== 3'b100) begin
            n_miss++;
            $display("FAIL full_n%0d: got v/b/r=%b want 100", n, {out_valid, busy, s_tready});
        end
        n_vec++;
        if (out !== exp_out) begin
            n_miss++;
            $display("FAIL data_n%0d: got %h want %h", n, out, exp_out);
        end
        n_vec++;
        if (err !== exp_err) begin
            n_miss++;
            $display("FAIL err_n%0d: got %b want %b", n, err, exp_err);
        end
    endtask

    // Acknowledge a full matrix, optionally with a simultaneous (ignored) start.
    task automatic test_release(input bit with_start);
        out_ack = 1'b1; start = with_start; n_dim = DW'(2);
        tick();
        out_ack = 1'b0; start = 1'b0;
        n_vec++;
        if ({out_valid, busy, s_tready} !== 3'b000) begin
            n_miss++;
            $display("FAIL release_s%0d: got v/b/r=%b want 000", with_start, {out_valid, busy, s_tready});
        end
        n_vec++;
        if ({out, err} !== {exp_out, exp_err}) begin
            n_miss++;
            $display("FAIL release_hold: got %h/%b want %h/%b", out, err, exp_out, exp_err);
        end
    endtask

    task automatic test_par_load();
        for (int k = 0; k < LEN; k++) par_in[k*WIDTH +: WIDTH] = WIDTH'(k + 100);
        par_load = 1'b1;
        tick();
        par_load = 1'b0;
        exp_out = par_in;
        n_vec++;
        if ({out_valid, busy, out} !== {2'b10, exp_out}) begin
            n_miss++;
            $display("FAIL par_idle: got v=%b b=%b %h want 10 %h", out_valid, busy, out, exp_out);
        end
        // Reload while held.
        random_par_in();
        par_load = 1'b1;
        tick();
        exp_out = par_in;
        n_vec++;
        if ({out_valid, out} !== {1'b1, exp_out}) begin
            n_miss++;
            $display("FAIL par_full: got v=%b %h want 1 %h", out_valid, out, exp_out);
        end
        // Reload together with ack: ack wins, contents kept.
        random_par_in();
        out_ack = 1'b1;
        tick();
        par_load = 1'b0; out_ack = 1'b0;
        n_vec++;
        if ({out_valid, out} !== {1'b0, exp_out}) begin
            n_miss++;
            $display("FAIL par_ack: got v=%b %h want 0 %h", out_valid, out, exp_out);
        end
        // par_load beats a simultaneous start in IDLE.
        random_par_in();
        par_load = 1'b1; start = 1'b1; n_dim = DW'(3);
        tick();
        par_load = 1'b0; start = 1'b0;
        exp_out = par_in;
        n_vec++;
        if ({out_valid, busy, out} !== {2'b10, exp_out}) begin
            n_miss++;
            $display("FAIL par_vs_start: got v=%b b=%b %h want 10 %h", out_valid, busy, out, exp_out);
        end
        test_release(1'b0);
        // par_load during FILL is ignored; the capture proceeds normally.
        start = 1'b1; n_dim = DW'(2);
        tick();
        start = 1'b0;
        exp_out = '0;
        random_par_in();
        par_load = 1'b1;
        tick();
        par_load = 1'b0;
        n_vec++;
        if ({out_valid, busy, out} !== {2'b01, exp_out}) begin
            n_miss++;
            $display("FAIL par_in_fill: got v=%b b=%b %h want 01 %h", out_valid, busy, out, exp_out);
        end
        for (int i = 0; i < 4; i++) begin
            s_tvalid = 1'b1; s_tdata = $urandom; s_tlast = (i == 3);
            exp_out[i*WIDTH +: WIDTH] = s_tdata;
            tick();
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        n_vec++;
        if ({out_valid, out} !== {1'b1, exp_out}) begin
            n_miss++;
            $display("FAIL par_fill_done: got v=%b %h want 1 %h", out_valid, out, exp_out);
        end
    endtask

    task automatic test_bad_dim();
        int dims[3] = '{5, 0, 7};
        foreach (dims[i]) begin
            start = 1'b1; n_dim = DW'(dims[i]);
            tick();
            start = 1'b0;
            n_vec++;
            if ({out_valid, busy, s_tready, out} !== {3'b000, exp_out}) begin
                n_miss++;
                $display("FAIL bad_dim_%0d: got v/b/r=%b %h want 000 %h", dims[i],
                         {out_valid, busy, s_tready}, out, exp_out);
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        start = 1'b1; n_dim = DW'(3);
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_tvalid = 1'b1; s_tdata = $urandom; s_tlast = 1'b0;
            tick();
        end
        s_tvalid = 1'b0;
        #2 rst = 1'b1;
        #1;
        exp_out = '0; exp_err = 1'b0;
        n_vec++;
        if ({out_valid, busy, s_tready, out} !== {3'b000, exp_out}) begin
            n_miss++;
            $display("FAIL reset_mid: got v/b/r=%b %h want 000 0", {out_valid, busy, s_tready}, out);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        test_capture(3, 2, -1);
        test_release(1'b0);
    endtask

    initial begin
        test_reset();
        test_capture(2, 0, -1);          // 1 beat per cycle, start-to-valid = n*n+1 edges
        test_release(1'b1);              // ack + start together: start ignored
        test_capture(4, 1, -1);          // back-to-back start right after release, toggling tvalid
        test_release(1'b0);
        for (int r = 0; r < 4; r++) begin
            test_capture(int'($urandom_range(1, N_MAX)), 2, -1);
            test_release(r[0]);
        end
        test_par_load();
        test_release(1'b0);
        test_bad_dim();
        test_reset_mid_fill();
        test_capture(2, 0, 1);           // early tlast: err only with the check enabled
        test_release(1'b0);
        test_capture(2, 0, -1);          // accepted start clears err
        test_release(1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
